// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg -- shared types and constants for the ALU command sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int FW_DEF    = 4;

   // ALU register load strobes are active-low
   localparam logic LOAD_ON  = 1'b0;
   localparam logic LOAD_OFF = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      EXEC   = 3'd3,
      DONE   = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// alu_op_sequencer -- sequences one command onto the shared ALU operand bus
// and returns the captured result over a valid/ready port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int FW    = FW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [FW-1:0]    cmd_f,
   input  logic             cmd_acc,
   output logic [WIDTH-1:0] alu_aorb,
   output logic             alu_sela,
   output logic             alu_selb,
   output logic             alu_en,
   output logic [FW-1:0]    alu_f,
   input  logic [WIDTH-1:0] alu_y,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             busy
);

   state_t           r_state;
   logic [WIDTH-1:0] r_a_q;
   logic [WIDTH-1:0] r_b_q;
   logic [FW-1:0]    r_f_q;
   logic             r_acc_q;
   logic [WIDTH-1:0] r_res_q;

   logic             w_accept;

   // cmd_ready depends only on state and res_ready, never on cmd_valid
   assign cmd_ready = (r_state == IDLE) || ((r_state == DONE) && res_ready);
   assign w_accept  = cmd_valid && cmd_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a_q   <= '0;
         r_b_q   <= '0;
         r_f_q   <= '0;
         r_acc_q <= 1'b0;
         r_res_q <= '0;
      end else if (w_accept) begin
         r_a_q   <= cmd_a;
         r_b_q   <= cmd_b;
         r_f_q   <= cmd_f;
         r_acc_q <= cmd_acc;
         r_state <= LOAD_A;
      end else begin
         case (r_state)
            LOAD_A:  r_state <= LOAD_B;
            LOAD_B:  r_state <= EXEC;
            EXEC: begin
               r_res_q <= alu_y;
               r_state <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Moore decode of the datapath controls from state and held command
   always_comb begin
      alu_aorb  = '0;
      alu_sela  = LOAD_OFF;
      alu_selb  = LOAD_OFF;
      alu_en    = 1'b0;
      res_valid = 1'b0;
      case (r_state)
         LOAD_A: begin
            alu_sela = LOAD_ON;
            alu_en   = 1'b1;
            alu_aorb = r_acc_q ? r_res_q : r_a_q;
         end
         LOAD_B: begin
            alu_selb = LOAD_ON;
            alu_en   = 1'b1;
            alu_aorb = r_b_q;
         end
         DONE:    res_valid = 1'b1;
         default: ;
      endcase
   end

   assign alu_f    = r_f_q;
   assign res_data = r_res_q;
   assign busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// tb_alu_op_sequencer -- bench for alu_op_sequencer with an adder ALU model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic [3:0] cmd_f;
   logic       cmd_acc;
   logic [3:0] alu_aorb;
   logic       alu_sela;
   logic       alu_selb;
   logic       alu_en;
   logic [3:0] alu_f;
   logic [3:0] alu_y;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_data;
   logic       busy;

   alu_op_sequencer #(.WIDTH(4), .FW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_f     (cmd_f),
      .cmd_acc   (cmd_acc),
      .alu_aorb  (alu_aorb),
      .alu_sela  (alu_sela),
      .alu_selb  (alu_selb),
      .alu_en    (alu_en),
      .alu_f     (alu_f),
      .alu_y     (alu_y),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU datapath model: A/B registers loaded from the shared bus
   logic [3:0] alu_ra = 4'd0;
   logic [3:0] alu_rb = 4'd0;
   always @(posedge clk) begin
      if (alu_en) begin
         if (!alu_sela) alu_ra <= alu_aorb;
         if (!alu_selb) alu_rb <= alu_aorb;
      end
   end
   assign alu_y = alu_ra + alu_rb;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] f;
      logic       acc;
      logic [3:0] exp_aorb;
      logic [3:0] exp_res;
   } vec_t;

   vec_t       tbl [4];
   logic [3:0] model_last;
   logic [3:0] exp_q [$];

   // Reference: result = (effective A + B) mod 16, effective A = last result when accumulating
   function automatic logic [3:0] model_result(input logic [3:0] a, input logic [3:0] b, input logic acc,
                                               input logic [3:0] last);
      int ea;
      ea = acc ? int'(last) : int'(a);
      return 4'((ea + int'(b)) % 16);
   endfunction

   // Starts with DUT idle, positioned at a negedge; ends at a negedge with DUT idle
   task automatic run_cmd(input vec_t v);
      cmd_a = v.a; cmd_b = v.b; cmd_f = v.f; cmd_acc = v.acc; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_a = ~v.a; cmd_b = ~v.b; cmd_f = ~v.f; cmd_acc = ~v.acc;
      @(negedge clk);
      check("loadA_sela", alu_sela, 0);
      check("loadA_selb", alu_selb, 1);
      check("loadA_en", alu_en, 1);
      check("loadA_aorb", alu_aorb, v.exp_aorb);
      check("loadA_cmd_ready", cmd_ready, 0);
      check("loadA_busy", busy, 1);
      @(negedge clk);
      check("loadB_sela", alu_sela, 1);
      check("loadB_selb", alu_selb, 0);
      check("loadB_aorb", alu_aorb, v.b);
      @(negedge clk);
      check("exec_en", alu_en, 0);
      check("exec_f", alu_f, v.f);
      check("exec_aorb", alu_aorb, 0);
      check("exec_res_valid", res_valid, 0);
      @(negedge clk);
      check("done_res_valid", res_valid, 1);
      check("done_res_data", res_data, v.exp_res);
      @(negedge clk);
      check("idle_res_valid", res_valid, 0);
      check("idle_busy", busy, 0);
      model_last = v.exp_res;
   endtask

   task automatic new_random_cmd();
      cmd_a   = 4'($urandom_range(0, 15));
      cmd_b   = 4'($urandom_range(0, 15));
      cmd_f   = 4'($urandom_range(0, 15));
      cmd_acc = 1'($urandom_range(0, 1));
      model_last = model_result(cmd_a, cmd_b, cmd_acc, model_last);
      exp_q.push_back(model_last);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int got, issued, last_cyc;
      bit acc_now, seen_valid;
      tbl[0] = '{a: 4'd3,  b: 4'd5, f: 4'b1101, acc: 1'b0, exp_aorb: 4'd3,  exp_res: 4'd8};
      tbl[1] = '{a: 4'd9,  b: 4'd7, f: 4'b0010, acc: 1'b1, exp_aorb: 4'd8,  exp_res: 4'd15};
      tbl[2] = '{a: 4'd4,  b: 4'd2, f: 4'b0110, acc: 1'b1, exp_aorb: 4'd15, exp_res: 4'd1};
      tbl[3] = '{a: 4'd15, b: 4'd1, f: 4'b0000, acc: 1'b0, exp_aorb: 4'd15, exp_res: 4'd0};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_f = '0; cmd_acc = 1'b0;
      res_ready = 1'b1; model_last = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset with no stimulus
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_cmd_ready", cmd_ready, 1);
         check("rst_res_valid", res_valid, 0);
         check("rst_sela", alu_sela, 1);
         check("rst_selb", alu_selb, 1);
         check("rst_en", alu_en, 0);
         check("rst_aorb", alu_aorb, 0);
         check("rst_alu_f", alu_f, 0);
         check("rst_busy", busy, 0);
      end

      for (int i = 0; i < 4; i++) run_cmd(tbl[i]);

      // Backpressure: hold result for 5 cycles, then accept next command from DONE
      res_ready = 1'b0;
      cmd_a = 4'd3; cmd_b = 4'd5; cmd_f = 4'd1; cmd_acc = 1'b0; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_res_valid", res_valid, 1);
         check("bp_res_data", res_data, 8);
         check("bp_cmd_ready", cmd_ready, 0);
      end
      res_ready = 1'b1;
      cmd_a = 4'd9; cmd_b = 4'd1; cmd_f = 4'd7; cmd_acc = 1'b1; cmd_valid = 1'b1;
      #1;
      check("bp_cmd_ready_release", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check("bp_next_sela", alu_sela, 0);
      check("bp_next_aorb", alu_aorb, 8);
      check("bp_next_res_valid", res_valid, 0);
      repeat (3) @(negedge clk);
      check("bp_next_res", res_data, 9);
      check("bp_next_valid", res_valid, 1);
      model_last = 4'd9;
      @(posedge clk); #1;

      // Randomized back-to-back commands against the reference model
      got = 0; issued = 1; last_cyc = 0;
      new_random_cmd();
      cmd_valid = 1'b1;
      for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
         @(negedge clk);
         acc_now = cmd_valid && cmd_ready;
         if (res_valid) begin
            if (exp_q.size() == 0) check("b2b_extra_result", 1, 0);
            else check("b2b_data", res_data, exp_q.pop_front());
            if (got > 0) check("b2b_spacing", cyc - last_cyc, 4);
            last_cyc = cyc;
            got++;
         end
         @(posedge clk); #1;
         if (acc_now) begin
            if (issued < 8) begin
               new_random_cmd();
               issued++;
            end else begin
               cmd_valid = 1'b0;
            end
         end
      end
      check("b2b_count", got, 8);
      cmd_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset pulsed during LOAD_B abandons the command
      cmd_a = 4'd5; cmd_b = 4'd5; cmd_f = 4'd3; cmd_acc = 1'b0; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mid_loadB_selb", alu_selb, 0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_cmd_ready", cmd_ready, 1);
      check("mid_rst_selb", alu_selb, 1);
      check("mid_rst_en", alu_en, 0);
      check("mid_rst_alu_f", alu_f, 0);
      check("mid_rst_res_data", res_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (res_valid) seen_valid = 1'b1;
      end
      check("mid_rst_no_result", seen_valid, 0);
      model_last = '0;
      run_cmd('{a: 4'd9, b: 4'd6, f: 4'hA, acc: 1'b1, exp_aorb: 4'd0,
                exp_res: model_result(4'd9, 4'd6, 1'b1, model_last)});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Upstream command sequencer for the 4-bit ALU datapath. It accepts one operation per valid/ready handshake (operand A, operand B, function code, accumulate flag) and sequences it onto the datapath's shared operand bus. It drives operand A into the A register, then operand B into the B register, then holds the function code for one execute cycle. It captures the ALU result and presents it on a valid/ready result port. In accumulate mode, the previous result is fed back as operand A, enabling chained operations without external storage.

## Interface
- WIDTH, 4, operand/result width
- FW, 4, function-code width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_a  in  WIDTH  operand A (ignored when cmd_acc=1)
- cmd_b  in  WIDTH  operand B
- cmd_f  in  FW  ALU function code
- cmd_acc  in  1  use last result as operand A
- alu_aorb  out  WIDTH  shared operand bus to ALU registers
- alu_sela  out  1  active-low load strobe, A register
- alu_selb  out  1  active-low load strobe, B register
- alu_en  out  1  ALU register enable
- alu_f  out  FW  ALU function select
- alu_y  in  WIDTH  ALU result (combinational from ALU registers and alu_f)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  captured result
- busy  out  1  state != IDLE

## Operation
- FSM states are IDLE, LOAD_A, LOAD_B, EXEC and DONE. All alu_* outputs are Moore-decoded from the state and the held command registers (a_q, b_q, f_q, acc_q).
- IDLE:
  - cmd_ready=1.
  - When cmd_valid=1, capture the command fields and go to LOAD_A.
- LOAD_A:
  - alu_sela=0, alu_en=1.
  - alu_aorb = acc_q ? res_q : a_q.
  - Next state is LOAD_B.
- LOAD_B:
  - alu_selb=0, alu_en=1, alu_aorb=b_q.
  - Next state is EXEC.
- EXEC:
  - alu_en=0.
  - res_q <= alu_y at the end of the cycle.
  - Next state is DONE.
- DONE:
  - res_valid=1, res_data=res_q.
  - If res_ready=0, stay in DONE.
  - If res_ready=1 and cmd_valid=0, go to IDLE.
  - If res_ready=1 and cmd_valid=1, capture the new command and go straight to LOAD_A (back-to-back).
  - cmd_ready = res_ready in DONE, 0 in LOAD_A/LOAD_B/EXEC.
- Outside their load state, alu_sela and alu_selb are 1. alu_en=0 in IDLE, EXEC and DONE. alu_aorb=0 in IDLE, EXEC and DONE.
- alu_f = f_q in every state.
- res_q holds its value until the next EXEC. Accumulate mode uses res_q whether or not it was consumed.
- The command is captured whole. Input changes after acceptance have no effect.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE
  - a_q=b_q=f_q=res_q=0, acc_q=0
  - cmd_ready=1, res_valid=0, busy=0
  - alu_sela=alu_selb=1, alu_en=0, alu_aorb=0, alu_f=0
- Latency: command accepted at edge E0, then A loaded at E1, B loaded at E2, result captured at E3. res_valid is high from E3.
- Throughput with res_ready tied high: one command per 4 cycles (back-to-back path).
- Handshake rules:
  - Transfers occur only on edges with valid&ready.
  - res_data is stable while res_valid=1 and res_ready=0.
  - cmd_ready never depends combinationally on cmd_valid.
- Reset asserted mid-sequence abandons the operation; no partial result is presented. The ALU registers are the datapath's responsibility.
- cmd_acc=1 as the first command after reset uses operand A=0.

## Structure
- Shared package alu_seq_pkg holds:
  - the state enum (IDLE, LOAD_A, LOAD_B, EXEC, DONE)
  - the WIDTH/FW defaults
  - the active-low strobe constants LOAD_ON=0 and LOAD_OFF=1
- No sub-module. The FSM, command registers and result register sit in one module.

## Test plan
All scenarios use a bench ALU model: registers loaded per alu_sela/alu_selb/alu_en, with alu_y = A+B mod 16.
- Reset release, no stimulus -> cmd_ready=1, res_valid=0, alu_sela=alu_selb=1, alu_en=0 indefinitely.
- cmd a=3, b=5, f=4'b1101, acc=0, res_ready=1 ->
  - LOAD_A: aorb=3, sela=0
  - LOAD_B: aorb=5, selb=0
  - EXEC: alu_f=1101
  - res_data=8 with res_valid high 3 cycles after acceptance.
- Accumulate: after previous result 8, send cmd b=7, acc=1 (cmd_a=9 ignored) -> LOAD_A drives aorb=8, result 15.
- Backpressure: res_ready=0 for 5 cycles in DONE -> res_valid and res_data=8 held, cmd_ready=0. Then res_ready=1 with cmd_valid=1 -> next cycle is LOAD_A.
- Back-to-back: 4 commands with cmd_valid and res_ready always 1 -> one result per 4 cycles, results in order.
- rst_n pulsed low during LOAD_B -> immediate IDLE, res_valid never asserts for that command, and the next command completes normally.
